inv_sbox_seq_unit: RTL and testbench
====================================

INV_SBOX_SEQ_UNIT -- requirements
Module: inv_sbox_seq_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning block width in bits (multiple of 8, 8..256).
REQ-002 SHALL have parameter LANES, default 4, meaning S-box lanes used per cycle (divides DATA_W/8).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_data  input  DATA_W  block to substitute, byte 0 = in_data[DATA_W-1:DATA_W-8].
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_ready  output  1  unit can accept a block.
REQ-008 SHALL have port out_data  output  DATA_W  substituted block.
REQ-009 SHALL have port out_valid  output  1  out_data valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-011 SHALL have port busy  output  1  high in state BUSY.

Function
REQ-012 SHALL define BEATS = (DATA_W/8)/LANES and a beat counter of width clog2(BEATS), minimum 1 bit.
REQ-013 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-014 Accept SHALL occur when in_valid & in_ready; the edge latches in_data into the work register, clears the beat counter, and enters BUSY.
REQ-015 Each BUSY cycle SHALL replace LANES bytes, starting at byte index counter*LANES, with their inverse S-box values, then increment the counter.
REQ-016 On the BEATS-th BUSY edge SHALL enter DONE with out_valid=1, so out_valid rises exactly BEATS edges after the accepting edge.
REQ-017 in_ready SHALL be 1 in IDLE, and also in DONE when out_ready=1 (back-to-back); 0 in BUSY.
REQ-018 In DONE with out_ready=1 and in_valid=1 SHALL complete output and accept the new block on the same edge, entering BUSY.
REQ-019 In DONE with out_ready=1 and in_valid=0 SHALL return to IDLE; with out_ready=0 SHALL hold out_data and out_valid stable.
REQ-020 out_data SHALL equal the work register; its value is defined only while out_valid=1.
REQ-021 in_valid during BUSY SHALL be ignored, with no state change.
REQ-022 BEATS=1 SHALL complete in one BUSY cycle.

Reset
REQ-023 While rst=1 SHALL force IDLE, counter=0, work register=0, out_valid=0, busy=0, in_ready=0.
REQ-024 in_ready SHALL rise the first edge after rst deasserts.
REQ-025 Reset mid-BUSY or mid-DONE SHALL discard the block with no out_valid pulse.

Configuration
REQ-026 With macro INV_SBOX_FWD_MODE_EN defined, SHALL add input port mode (1 bit, latched at accept; 1 = forward S-box, 0 = inverse).
REQ-027 Without INV_SBOX_FWD_MODE_EN, SHALL have no mode port and SHALL apply inverse only.

Structure
REQ-028 A shared package inv_sbox_pkg SHALL hold the FSM state typedef, the 256-entry inverse table and, when INV_SBOX_FWD_MODE_EN is defined, the forward table.
REQ-029 Lane logic SHALL be LANES instances of the existing 8-bit S_Inv_Sbox sub-module, plus forward lookup when INV_SBOX_FWD_MODE_EN is defined.
REQ-030 Parameter legality SHALL be checked at elaboration.

Verification
REQ-031 Default params, in_data=all 0x63, out_ready=1 -> out_valid 4 edges after accept, out_data=all 0x00.
REQ-032 in_data=0x00...00FF -> out_data=0x52...527D; in_valid held during BUSY -> no second accept.
REQ-033 out_ready=0 for 5 cycles in DONE -> out_data and out_valid stable; then accept a second block same edge as output.
REQ-034 rst pulsed mid-BUSY -> out_valid never asserts; in_ready=1 one edge after release.
REQ-035 DATA_W=32, LANES=4, in_data=0x7C7C7C7C -> out_valid 1 edge after accept, out_data=0x01010101.
REQ-036 With INV_SBOX_FWD_MODE_EN, mode=1, in_data=0x00...0053 -> out_data=0x63...63ED.

Source files
------------

// File: rtl/inv_sbox_pkg.sv
// Shared S-box tables, FSM state type and lookup helpers for the sequential substitution unit.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable. The forward table exists only when INV_SBOX_FWD_MODE_EN is defined.
package inv_sbox_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // AES inverse S-box, indexed by the input byte
    localparam logic [7:0] INV_SBOX_TBL [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[b];
    endfunction

`ifdef INV_SBOX_FWD_MODE_EN
    // AES forward S-box, indexed by the input byte
    localparam logic [7:0] FWD_SBOX_TBL [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
        return FWD_SBOX_TBL[b];
    endfunction
`endif

endpackage

// File: rtl/S_Inv_Sbox.sv
// Single-byte AES inverse S-box lookup lane.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input every cycle.
module S_Inv_Sbox
    import inv_sbox_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // table lookup for one byte
    always_comb begin
        out_byte = inv_sbox(in_byte);
    end

endmodule

// File: rtl/inv_sbox_seq_unit.sv
// Sequential block substitution: LANES bytes per cycle through inverse (optionally forward) S-boxes.
// Latency: out_valid rises BEATS = (DATA_W/8)/LANES edges after the accepting edge.
// Backpressure: result held in DONE while out_ready=0; in_ready low in BUSY. Optional macro INV_SBOX_FWD_MODE_EN adds port mode.
module inv_sbox_seq_unit
    import inv_sbox_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int LANES  = 4
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef INV_SBOX_FWD_MODE_EN
    input  logic              mode,
`endif
    output logic              busy
);

    localparam int NBYTES = DATA_W / 8;
    localparam int BEATS  = (LANES > 0) ? (NBYTES / LANES) : 1;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    // reject illegal geometry while elaborating
    generate
        if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > 256 || LANES < 1 || (NBYTES % LANES) != 0) begin : g_param_err
            $error("inv_sbox_seq_unit: DATA_W must be a multiple of 8 in 8..256 and LANES must divide DATA_W/8");
        end
    endgenerate

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] work_q, work_d;
    logic              init_q, init_d;
    logic              accept;
    logic [7:0]        lane_in  [LANES];
    logic [7:0]        lane_inv [LANES];
    logic [7:0]        lane_out [LANES];
`ifdef INV_SBOX_FWD_MODE_EN
    logic              mode_q, mode_d;
`endif

    // state and datapath registers; init_q keeps in_ready low until the first edge out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            init_q  <= 1'b0;
`ifdef INV_SBOX_FWD_MODE_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            init_q  <= init_d;
`ifdef INV_SBOX_FWD_MODE_EN
            mode_q  <= mode_d;
`endif
        end
    end

    // next-state: one BUSY cycle per beat, DONE holds until the consumer takes the block
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_BUSY;
            ST_BUSY: if (cnt_q == CNT_W'(BEATS - 1)) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = accept ? ST_BUSY : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // outputs decoded from state; DONE with out_ready=1 can take the next block on the same edge
    always_comb begin
        in_ready  = ((state_q == ST_IDLE) && init_q) || ((state_q == ST_DONE) && out_ready);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q == ST_BUSY);
        out_data  = work_q;
        accept    = in_valid && in_ready;
    end

    // pick the LANES bytes addressed by the beat counter (byte 0 is the MSB byte)
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = '0;
        end
        for (int b = 0; b < BEATS; b++) begin
            if (cnt_q == CNT_W'(b)) begin
                for (int l = 0; l < LANES; l++) begin
                    lane_in[l] = work_q[DATA_W-1-8*(b*LANES+l) -: 8];
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            S_Inv_Sbox u_lane (
                .in_byte  (lane_in[g]),
                .out_byte (lane_inv[g])
            );
        end
    endgenerate

    // per-lane direction select; inverse only unless the forward option is built in
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
`ifdef INV_SBOX_FWD_MODE_EN
            lane_out[l] = mode_q ? fwd_sbox(lane_in[l]) : lane_inv[l];
`else
            lane_out[l] = lane_inv[l];
`endif
        end
    end

    // datapath update: load on accept, else substitute the current beat while BUSY
    always_comb begin
        work_d = work_q;
        cnt_d  = cnt_q;
        init_d = 1'b1;
`ifdef INV_SBOX_FWD_MODE_EN
        mode_d = mode_q;
`endif
        if (accept) begin
            work_d = in_data;
            cnt_d  = '0;
`ifdef INV_SBOX_FWD_MODE_EN
            mode_d = mode;
`endif
        end else if (state_q == ST_BUSY) begin
            for (int b = 0; b < BEATS; b++) begin
                if (cnt_q == CNT_W'(b)) begin
                    for (int l = 0; l < LANES; l++) begin
                        work_d[DATA_W-1-8*(b*LANES+l) -: 8] = lane_out[l];
                    end
                end
            end
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_inv_sbox_seq_unit.sv
// Directed bench for inv_sbox_seq_unit: 128/4 instance and a 32/4 single-beat instance.
// Latency expectations: 4 edges (128-bit) and 1 edge (32-bit) from accept to out_valid.
// Backpressure exercised through out_ready stalls and held in_valid during BUSY.
module tb_inv_sbox_seq_unit;

    localparam int W = 128;
    localparam int EXP_LAT = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic           busy;

    logic [31:0]    s_in_data;
    logic           s_in_valid;
    logic           s_in_ready;
    logic [31:0]    s_out_data;
    logic           s_out_valid;
    logic           s_out_ready;
    logic           s_busy;
`ifdef INV_SBOX_FWD_MODE_EN
    logic           mode;
    logic           s_mode;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    inv_sbox_seq_unit #(.DATA_W(128), .LANES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef INV_SBOX_FWD_MODE_EN
        .mode      (mode),
`endif
        .busy      (busy)
    );

    inv_sbox_seq_unit #(.DATA_W(32), .LANES(4)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .in_data   (s_in_data),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .out_data  (s_out_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
`ifdef INV_SBOX_FWD_MODE_EN
        .mode      (s_mode),
`endif
        .busy      (s_busy)
    );

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] exp;
        bit           hold;
        string        name;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // called just after the accepting edge; counts edges until out_valid (bounded)
    task automatic wait_out(output int lat, output bit guard_ok, input bit drop_at3);
        lat = 0;
        guard_ok = 1'b1;
        while (!out_valid && lat < 20) begin
            if (in_ready || !busy) guard_ok = 1'b0;
            tick();
            lat++;
            if (drop_at3 && lat == 3) in_valid = 1'b0;
        end
    endtask

    task automatic run_block(input logic [W-1:0] din, input logic [W-1:0] exp, input bit hold, input string name);
        int lat;
        bit guard_ok;
        int n;
        in_data  = din;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk({name, " in_ready"}, W'(in_ready), W'(1));
        tick();
        if (hold) in_data = ~din;
        else in_valid = 1'b0;
        wait_out(lat, guard_ok, hold);
        chk({name, " latency"}, W'(lat), W'(EXP_LAT));
        chk({name, " busy_no_rdy"}, W'(guard_ok), W'(1));
        chk({name, " data"}, out_data, exp);
    endtask

    initial begin
        int  lat;
        bit  guard_ok;
        bit  seen;

        vecs[0] = '{din: {16{8'h63}}, exp: {16{8'h00}}, hold: 1'b0, name: "all63"};
        vecs[1] = '{din: {{15{8'h00}}, 8'hFF}, exp: {{15{8'h52}}, 8'h7D}, hold: 1'b1, name: "ff_hold"};
        vecs[2] = '{din: {16{8'h7C}}, exp: {16{8'h01}}, hold: 1'b0, name: "all7c"};
        vecs[3] = '{din: 128'h000102030405060708090a0b0c0d0e0f,
                    exp: 128'h52096ad53036a538bf40a39e81f3d7fb, hold: 1'b0, name: "ramp00"};
        vecs[4] = '{din: 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff,
                    exp: 128'h172b047eba77d626e169146355210c7d, hold: 1'b0, name: "rampf0"};
        vecs[5] = '{din: {16{8'h00}}, exp: {16{8'h52}}, hold: 1'b0, name: "all00"};
        vecs[6] = '{din: {16{8'hFF}}, exp: {16{8'h7D}}, hold: 1'b1, name: "allff_hold"};

        rst         = 1'b1;
        in_data     = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        s_in_data   = '0;
        s_in_valid  = 1'b0;
        s_out_ready = 1'b1;
`ifdef INV_SBOX_FWD_MODE_EN
        mode        = 1'b0;
        s_mode      = 1'b0;
`endif

        // reset state, both asynchronously and after clocks under reset
        #2;
        chk("rst out_valid", W'(out_valid), W'(0));
        chk("rst busy", W'(busy), W'(0));
        chk("rst in_ready", W'(in_ready), W'(0));
        chk("rst out_data", out_data, '0);
        tick();
        tick();
        chk("rst in_ready clocked", W'(in_ready), W'(0));
        chk("rst s_in_ready", W'(s_in_ready), W'(0));
        rst = 1'b0;
        #1;
        chk("release in_ready pre-edge", W'(in_ready), W'(0));
        tick();
        chk("release in_ready", W'(in_ready), W'(1));
        chk("release s_in_ready", W'(s_in_ready), W'(1));

        // table vectors, back-to-back through DONE
        for (int i = 0; i < 7; i++) begin
            run_block(vecs[i].din, vecs[i].exp, vecs[i].hold, vecs[i].name);
        end

        // output stall for 5 cycles, then hand-off and accept on the same edge
        in_data  = {16{8'h63}};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out(lat, guard_ok, 1'b0);
        chk("stall latency", W'(lat), W'(EXP_LAT));
        out_ready = 1'b0;
        in_data   = {16{8'h7C}};
        in_valid  = 1'b1;
        #1;
        chk("stall in_ready low", W'(in_ready), W'(0));
        seen = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (!out_valid || out_data !== {16{8'h00}}) seen = 1'b0;
        end
        chk("stall held stable", W'(seen), W'(1));
        chk("stall data", out_data, {16{8'h00}});
        out_ready = 1'b1;
        #1;
        chk("handoff in_ready", W'(in_ready), W'(1));
        tick();
        in_valid = 1'b0;
        chk("handoff out_valid drop", W'(out_valid), W'(0));
        chk("handoff busy", W'(busy), W'(1));
        wait_out(lat, guard_ok, 1'b0);
        chk("handoff latency", W'(lat), W'(EXP_LAT));
        chk("handoff data", out_data, {16{8'h01}});

        // reset in the middle of BUSY
        in_data  = {16{8'h00}};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("midbusy busy before rst", W'(busy), W'(1));
        rst = 1'b1;
        #1;
        chk("midbusy rst busy", W'(busy), W'(0));
        chk("midbusy rst in_ready", W'(in_ready), W'(0));
        seen = out_valid;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("midbusy release in_ready pre-edge", W'(in_ready), W'(0));
        tick();
        chk("midbusy release in_ready", W'(in_ready), W'(1));
        for (int c = 0; c < 8; c++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        chk("midbusy no out_valid", W'(seen), W'(0));

        // 32-bit instance: single beat
        s_in_data  = 32'h7C7C7C7C;
        s_in_valid = 1'b1;
        #1;
        chk("s in_ready", W'(s_in_ready), W'(1));
        tick();
        s_in_valid = 1'b0;
        chk("s busy after accept", W'(s_busy), W'(1));
        chk("s out_valid after accept", W'(s_out_valid), W'(0));
        tick();
        chk("s out_valid 1 edge", W'(s_out_valid), W'(1));
        chk("s data", W'(s_out_data), W'(32'h01010101));
        tick();
        chk("s back to idle", W'(s_out_valid), W'(0));

`ifdef INV_SBOX_FWD_MODE_EN
        // forward direction selected at accept
        mode = 1'b1;
        run_block({{15{8'h00}}, 8'h53}, {{15{8'h63}}, 8'hED}, 1'b0, "fwd53");
        mode = 1'b0;
        run_block({{15{8'h00}}, 8'hFF}, {{15{8'h52}}, 8'h7D}, 1'b0, "inv_after_fwd");
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
